// File: rtl/gate_truth_checker.sv
// Drives a 2-input gate through 00,01,10,11 and checks y
// against a truth table, reporting pass, error count and fail mask.
module gate_truth_checker #(
   parameter int          HOLD_CYCLES  = 10,
   parameter logic [3:0]  EXPECT_TABLE = 4'b0111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

   generate
      if (HOLD_CYCLES < 1) begin : g_bad_hold
         $error("HOLD_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CHECK
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      vec_q, vec_d;
   logic [1:0]      ab_q, ab_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [2:0]      err_q, err_d;
   logic [3:0]      mask_q, mask_d;
   logic            miss;

   assign miss = (y != EXPECT_TABLE[vec_q]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= 2'd0;
         ab_q    <= 2'd0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 3'd0;
         mask_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         ab_q    <= ab_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      ab_d    = ab_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      mask_d  = mask_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETTLE;
               vec_d   = 2'd0;
               ab_d    = 2'd0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = 3'd0;
               mask_d  = 4'd0;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (miss) begin
               err_d         = err_q + 3'd1;
               mask_d[vec_q] = 1'b1;
            end
            // pass must include the last vector's verdict
            if (vec_q != 2'd3) begin
               vec_d   = vec_q + 2'd1;
               ab_d    = vec_q + 2'd1;
               cnt_d   = '0;
               state_d = SETTLE;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ab_d    = 2'd0;
               pass_d  = (err_d == 3'd0);
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign a         = ab_q[1];
   assign b         = ab_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_mask = mask_q;

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Self-checking stimulus/response stage that sits directly upstream of a 2-input combinational gate.
- Drives the gate's a/b inputs through all four combinations (00, 01, 10, 11) and holds each for a programmable settle time.
- Samples the gate output y and compares it against a parameterised expected truth table.
- Reports pass/fail, an error count and a per-vector failure mask; lets on-chip or FPGA bring-up verify gate blocks without a simulator.

Parameters:
- HOLD_CYCLES, 10, settle cycles per vector before sampling; must be >= 1.
- EXPECT_TABLE, 4'b0111, expected y indexed by {a,b}; bit[i] = expected y for vector i. Default is NAND.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request; sampled only when not busy.
- a  output  1  gate input a, registered.
- b  output  1  gate input b, registered.
- y  input  1  gate output under test; sampled synchronously.
- busy  output  1  high while a run is in progress.
- done  output  1  high from end of run until next accepted start.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  3  number of mismatching vectors, 0..4.
- fail_mask  output  4  bit[i]=1 if vector i mismatched.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0.
  - Internal vec=0, settle counter=0, state IDLE.
- States: IDLE, SETTLE, CHECK.
- IDLE:
  - On the edge where start=1, load vec=0 and drive {a,b}=2'b00.
  - Set busy=1; clear done, pass, err_count and fail_mask; cnt=0; go to SETTLE.
  - start=0 leaves the state unchanged.
- SETTLE:
  - cnt increments each edge.
  - When cnt==HOLD_CYCLES-1, go to CHECK on that edge.
  - SETTLE therefore lasts exactly HOLD_CYCLES cycles.
- CHECK (exactly one cycle):
  - At the end edge, compare y to EXPECT_TABLE[vec].
  - Mismatch: err_count += 1 and fail_mask[vec] = 1, both updated at the same edge.
  - If vec<3: vec += 1, drive {a,b}=vec+1, cnt=0, go to SETTLE.
  - If vec==3:
    - busy=0, done=1, {a,b}=2'b00, go to IDLE.
    - pass = (final err_count==0), including vector 3's result, all at the same edge.
- Timing:
  - Each vector is held HOLD_CYCLES+1 cycles.
  - done rises 4*(HOLD_CYCLES+1) edges after the start-accept edge (44 at default).
  - y is sampled at the final edge of each vector's hold window.
- start while busy=1 is ignored; no restart, no effect on results.
- start while done=1 (IDLE) is accepted: done, pass and results clear at the accept edge and a new run begins.
- Outputs err_count and fail_mask are visible and updating during the run; pass stays 0 until done.
- err_count saturation is not needed; the maximum is 4 and fits in 3 bits.
- y is treated as a plain bit. No X handling in RTL; the bench drives known values.
- Counter width is $clog2(HOLD_CYCLES+1). HOLD_CYCLES<1 is illegal and flagged by an elaboration-time check.
- Reset mid-run aborts immediately to the reset values. The next start begins again at vector 00 with cleared results.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle during a run -> a=b=busy=done=pass=0, err_count=0, fail_mask=0 before the next clock edge.
- Correct NAND model, HOLD_CYCLES=10, one-cycle start pulse ->
  - {a,b} = 00, 01, 10, 11, each held 11 cycles.
  - done=1 and busy=0 exactly 44 edges after the accept.
  - pass=1, err_count=0, fail_mask=4'b0000, a=b=0 after done.
- Faulty model, y stuck at 1 -> err_count=1, fail_mask=4'b1000, pass=0.
- Faulty model, AND behaviour -> err_count=4, fail_mask=4'b1111, pass=0.
- start held high for the entire run, plus extra pulses mid-run ->
  - Single run with identical timing to scenario 2.
  - After done, start still high causes an immediate re-accept: done clears on the next edge.
- HOLD_CYCLES=1 -> each vector held 2 cycles, done 8 edges after accept.
- Reset asserted while vector 10 is driven, then a new start -> the run restarts at 00 with fresh counts.
